sap1_microsequencer: RTL and testbench
======================================

Name: sap1_microsequencer

Overview:
- Horizontal microprogrammed control unit for the 8-bit SAP-1 core. Sits directly upstream of the datapath and drives its 17-bit control word.
- Holds a 5-bit micro-program counter (uPC) and a 32-word control store.
- Microword sequencing bits (LOAD/CLR/INC) select the next uPC. The 4-bit IR opcode maps to each instruction's microroutine start address.
- Supports LDA, ADD, SUB, OUT, HLT, plus single-step gating via en.

Parameters:
- UADDR_W, 5, uPC / control-store address width
- CW_W, 17, control word width
- OP_LDA, 4'b0000, LDA opcode
- OP_ADD, 4'b0001, ADD opcode
- OP_SUB, 4'b0010, SUB opcode
- OP_OUT, 4'b1110, OUT opcode
- OP_HLT, 4'b1111, HLT opcode

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  step enable; low freezes uPC and zeroes cw
- ir_opcode  in  4  opcode field from instruction register
- cw  out  17  control word: [16]EP [15]CP [14]LM [13]CE [12]LI [11]EI [10]CS [9]LOAD [8]CLR [7]INC [6]LA [5]EA [4]LB [3]SU [2]AD [1]EU [0]LO
- count_out  out  5  current uPC
- instr_done  out  1  high during last microword of an instruction (CLR set and en=1)
- halted  out  1  high while uPC = 13 (HLT word)

Behaviour:
Clock and reset:
- One clock: clk. Reset rst is asynchronous and active-high.
- While rst=1: uPC=0, cw=0, instr_done=0, halted=0.
- After rst deasserts, cw reflects the control-store word at uPC=0.

Output timing:
- cw = ROM[uPC] when en=1 and rst=0, else 0. This is combinational from the registered uPC, with zero-cycle latency to the datapath.

Next-uPC at rising clk edge when en=1 (priority CLR > LOAD > INC > hold):
- CLR -> 0
- LOAD -> map(ir_opcode)
- INC -> uPC+1, wrapping 31->0
- none -> hold
- en=0 -> hold regardless.

Opcode map:
- LDA -> 4, ADD -> 6, SUB -> 9, OUT -> 12, HLT -> 13
- Any other opcode -> 0 (NOP; refetch next instruction).

Control store (hex):
- 0 = 14080 (EP LM INC)
- 1 = 08080 (CP INC)
- 2 = 03480 (CE CS LI INC)
- 3 = 00200 (LOAD)
- 4 = 04880 (EI LM INC)
- 5 = 02540 (CE CS LA CLR)
- 6 = 04880
- 7 = 02490 (CE CS LB INC)
- 8 = 00146 (AD EU LA CLR)
- 9 = 04880
- 10 = 02490
- 11 = 0014A (SU EU LA CLR)
- 12 = 00121 (EA LO CLR)
- 13 = 00000 (HLT; no sequencing bits, so uPC holds forever)
- 14..31 = 00100 (CLR; recovery)

Instruction length, counted from uPC=0: LDA 6 clocks, ADD 7, SUB 7, OUT 5.

Rules:
- ir_opcode is sampled only on the LOAD edge (uPC=3). IR is loaded on the uPC=2 edge, so the opcode is stable by then.
- HLT is sticky; only rst exits it. en toggling does not release it.
- instr_done and halted are never high together.
- Reset mid-routine aborts immediately: uPC=0 asynchronously, no partial microword completes.
- SU and AD are never both set in any word.

Test Plan:
- rst pulse, en=1, ir_opcode=0000, 6 clocks -> count_out 0,1,2,3,4,5 then 0; cw sequence 14080,08080,03480,00200,04880,02540; instr_done high only at uPC=5.
- ir_opcode=0001 then 0010 -> ADD visits 0-3,6,7,8 (cw at 8 = 00146); SUB visits 0-3,9,10,11 (cw at 11 = 0014A); each returns to 0 after 7 clocks.
- ir_opcode=1110 -> 0,1,2,3,12 then 0; cw at 12 = 00121 (EA, LO, CLR). Then ir_opcode=1111 -> uPC reaches 13 and holds 10+ clocks, halted=1, cw=0.
- ir_opcode=0101 (illegal) -> after uPC=3, uPC=0 next clock; no LA/LB/LO ever asserted.
- en=0 for 3 clocks at uPC=7 -> uPC stays 7, cw=0; en=1 -> cw=02490, then uPC=8.
- rst asserted asynchronously mid-clock at uPC=8 -> count_out=0, cw=0 immediately, without waiting for a clk edge; normal fetch resumes after release.

Source files
------------

// File: rtl/sap1_microsequencer.sv
// SAP-1 horizontal microprogrammed control unit: 5-bit uPC, 32-word control store,
// opcode-to-microroutine mapping and single-step gating of the 17-bit control word.
module sap1_microsequencer #(
    parameter int unsigned UADDR_W = 5,
    parameter int unsigned CW_W    = 17,
    parameter logic [3:0]  OP_LDA  = 4'b0000,
    parameter logic [3:0]  OP_ADD  = 4'b0001,
    parameter logic [3:0]  OP_SUB  = 4'b0010,
    parameter logic [3:0]  OP_OUT  = 4'b1110,
    parameter logic [3:0]  OP_HLT  = 4'b1111
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [3:0]         ir_opcode,
    output logic [CW_W-1:0]    cw,
    output logic [UADDR_W-1:0] count_out,
    output logic               instr_done,
    output logic               halted
);

    localparam int unsigned BIT_LOAD = 9;
    localparam int unsigned BIT_CLR  = 8;
    localparam int unsigned BIT_INC  = 7;

    logic [UADDR_W-1:0] r_upc;
    logic [UADDR_W-1:0] w_upc_next;
    logic [UADDR_W-1:0] w_map_addr;
    logic [CW_W-1:0]    w_rom;

    always_comb begin
        w_rom = '0;
        case (r_upc)
            5'd0:    w_rom = 17'h14080;
            5'd1:    w_rom = 17'h08080;
            5'd2:    w_rom = 17'h03480;
            5'd3:    w_rom = 17'h00200;
            5'd4:    w_rom = 17'h04880;
            5'd5:    w_rom = 17'h02540;
            5'd6:    w_rom = 17'h04880;
            5'd7:    w_rom = 17'h02490;
            5'd8:    w_rom = 17'h00146;
            5'd9:    w_rom = 17'h04880;
            5'd10:   w_rom = 17'h02490;
            5'd11:   w_rom = 17'h0014A;
            5'd12:   w_rom = 17'h00121;
            5'd13:   w_rom = 17'h00000;
            default: w_rom = 17'h00100;
        endcase
    end

    // Unknown opcodes map to 0 so the machine simply refetches.
    always_comb begin
        w_map_addr = '0;
        case (ir_opcode)
            OP_LDA:  w_map_addr = 5'd4;
            OP_ADD:  w_map_addr = 5'd6;
            OP_SUB:  w_map_addr = 5'd9;
            OP_OUT:  w_map_addr = 5'd12;
            OP_HLT:  w_map_addr = 5'd13;
            default: w_map_addr = '0;
        endcase
    end

    always_comb begin
        w_upc_next = r_upc;
        if (en) begin
            if (w_rom[BIT_CLR])
                w_upc_next = '0;
            else if (w_rom[BIT_LOAD])
                w_upc_next = w_map_addr;
            else if (w_rom[BIT_INC])
                w_upc_next = r_upc + UADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_upc <= '0;
        else
            r_upc <= w_upc_next;
    end

    assign cw         = (en && !rst) ? w_rom : '0;
    assign count_out  = r_upc;
    assign instr_done = cw[BIT_CLR];
    assign halted     = (r_upc == 5'd13);

endmodule

// File: tb/tb_sap1_microsequencer.sv
// Self-checking bench for sap1_microsequencer: expected uPC/done traces are queued
// per instruction and compared one clock at a time against the DUT outputs.
module tb_sap1_microsequencer;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  ir_opcode;
    logic [16:0] cw;
    logic [4:0]  count_out;
    logic        instr_done;
    logic        halted;

    int unsigned n_checks;
    int unsigned n_fail;

    typedef struct {
        int unsigned upc;
        logic        done;
    } exp_t;

    exp_t sb[$];

    sap1_microsequencer dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .ir_opcode  (ir_opcode),
        .cw         (cw),
        .count_out  (count_out),
        .instr_done (instr_done),
        .halted     (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [16:0] rom_exp(input int unsigned a);
        case (a)
            0:  return 17'h14080;
            1:  return 17'h08080;
            2:  return 17'h03480;
            3:  return 17'h00200;
            4:  return 17'h04880;
            5:  return 17'h02540;
            6:  return 17'h04880;
            7:  return 17'h02490;
            8:  return 17'h00146;
            9:  return 17'h04880;
            10: return 17'h02490;
            11: return 17'h0014A;
            12: return 17'h00121;
            13: return 17'h00000;
            default: return 17'h00100;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue a microroutine trace; the last entry carries instr_done when the routine ends in CLR.
    task automatic push_trace(input int unsigned addrs[$], input logic ends_clr);
        exp_t e;
        for (int i = 0; i < addrs.size(); i++) begin
            e.upc  = addrs[i];
            e.done = ends_clr && (i == addrs.size() - 1);
            sb.push_back(e);
        end
    endtask

    task automatic drain(input string tag);
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, ".upc"},    32'(count_out),  32'(e.upc));
            check({tag, ".cw"},     32'(cw),         32'(rom_exp(e.upc)));
            check({tag, ".done"},   32'(instr_done), 32'(e.done));
            check({tag, ".halted"}, 32'(halted),     32'(e.upc == 13));
            step();
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        en        = 1'b1;
        ir_opcode = 4'b0000;
        #12;
        check("rst.upc",    32'(count_out),  32'd0);
        check("rst.cw",     32'(cw),         32'd0);
        check("rst.done",   32'(instr_done), 32'd0);
        check("rst.halted", 32'(halted),     32'd0);
        rst = 1'b0;
        #1;

        ir_opcode = 4'b0000;
        push_trace('{0, 1, 2, 3, 4, 5}, 1'b1);
        drain("lda");

        ir_opcode = 4'b0001;
        push_trace('{0, 1, 2, 3, 6, 7, 8}, 1'b1);
        drain("add");

        ir_opcode = 4'b0010;
        push_trace('{0, 1, 2, 3, 9, 10, 11}, 1'b1);
        drain("sub");

        ir_opcode = 4'b1110;
        push_trace('{0, 1, 2, 3, 12}, 1'b1);
        drain("out");

        ir_opcode = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            check("ill.upc", 32'(count_out), 32'(i));
            check("ill.no_la_lb_lo", 32'({cw[6], cw[4], cw[0]}), 32'd0);
            check("ill.done", 32'(instr_done), 32'd0);
            step();
        end
        check("ill.refetch", 32'(count_out), 32'd0);

        ir_opcode = 4'b0001;
        push_trace('{0, 1, 2, 3, 6}, 1'b0);
        drain("stall_pre");
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall.upc",  32'(count_out),  32'd7);
            check("stall.cw",   32'(cw),         32'd0);
            check("stall.done", 32'(instr_done), 32'd0);
            step();
        end
        en = 1'b1;
        #1;
        check("resume.cw",  32'(cw),        32'h02490);
        check("resume.upc", 32'(count_out), 32'd7);
        step();
        check("resume.upc8", 32'(count_out),  32'd8);
        check("resume.cw8",  32'(cw),         32'h00146);
        check("resume.done", 32'(instr_done), 32'd1);
        step();
        check("resume.wrap", 32'(count_out), 32'd0);

        push_trace('{0, 1, 2, 3, 6, 7}, 1'b0);
        drain("arst_pre");
        check("arst.at8", 32'(count_out), 32'd8);
        #2;
        rst = 1'b1;
        #1;
        check("arst.upc",  32'(count_out),  32'd0);
        check("arst.cw",   32'(cw),         32'd0);
        check("arst.done", 32'(instr_done), 32'd0);
        step();
        check("arst.hold", 32'(count_out), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        check("arst.rel_cw", 32'(cw), 32'h14080);
        ir_opcode = 4'b0000;
        push_trace('{0, 1, 2, 3, 4, 5}, 1'b1);
        drain("post_rst");

        ir_opcode = 4'b1111;
        push_trace('{0, 1, 2, 3}, 1'b0);
        drain("hlt_pre");
        for (int i = 0; i < 12; i++) begin
            check("hlt.upc",    32'(count_out),  32'd13);
            check("hlt.halted", 32'(halted),     32'd1);
            check("hlt.cw",     32'(cw),         32'd0);
            check("hlt.done",   32'(instr_done), 32'd0);
            step();
        end
        en = 1'b0;
        step();
        step();
        en = 1'b1;
        #1;
        check("hlt.en_toggle_upc", 32'(count_out), 32'd13);
        step();
        check("hlt.sticky_upc",    32'(count_out), 32'd13);
        check("hlt.sticky_halted", 32'(halted),    32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
